// File: rtl/dp_axi_polyvec_loader.sv
// dp_axi_polyvec_loader
// Upstream write stage of the triple ping-pong polyvec buffer. Takes a
// valid/ready coefficient stream of NUM_BASE_BANK lanes per beat and writes
// NUM_POLY polys of 1<<ADDR_WIDTH words each into the buffer's write port.
// Each load is armed by i_start. One cycle after the last write-enable cycle,
// o_done pulses so the buffer rotates only after the final word is stored.
// The word count decides when a poly ends. s_last is only cross-checked
// against the count, and any disagreement is flagged in o_err_last.
module dp_axi_polyvec_loader #(
   parameter int COE_WIDTH     = 39,
   parameter int ADDR_WIDTH    = 9,
   parameter int NUM_POLY      = 3,
   parameter int NUM_BASE_BANK = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                i_start,
   input  logic                                s_valid,
   output logic                                s_ready,
   input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  s_data,
   input  logic                                s_last,
   output logic [NUM_BASE_BANK*NUM_POLY-1:0]   o_axi_we,
   output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] o_axi_wraddr,
   output logic [COE_WIDTH*NUM_BASE_BANK-1:0]  o_axi_data,
   output logic                                o_done,
   output logic                                o_busy,
   output logic                                o_err_last
);

   localparam int PW = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                              r_state;
   logic                                r_ready;
   logic [NUM_BASE_BANK*NUM_POLY-1:0]   r_we;
   logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] r_wraddr;
   logic [COE_WIDTH*NUM_BASE_BANK-1:0]  r_data;
   logic                                r_done;
   logic                                r_busy;
   logic                                r_err;
   logic [ADDR_WIDTH-1:0]               r_word_cnt;
   logic [PW-1:0]                       r_poly_idx;

   logic                                w_accept;
   logic                                w_last_word;
   logic                                w_last_poly;
   logic [NUM_BASE_BANK*NUM_POLY-1:0]   w_we_group;

   assign w_accept    = s_valid & r_ready;
   assign w_last_word = (r_word_cnt == {ADDR_WIDTH{1'b1}});
   assign w_last_poly = (r_poly_idx == PW'(NUM_POLY - 1));

   // Decode the current poly index into its bank write-enable group.
   always_comb begin
      w_we_group = {(NUM_BASE_BANK*NUM_POLY){1'b0}};
      for (int p = 0; p < NUM_POLY; p++) begin
         if (r_poly_idx == PW'(p)) begin
            w_we_group[p*NUM_BASE_BANK +: NUM_BASE_BANK] = {NUM_BASE_BANK{1'b1}};
         end else begin
            w_we_group[p*NUM_BASE_BANK +: NUM_BASE_BANK] = {NUM_BASE_BANK{1'b0}};
         end
      end
   end

   // Load FSM: state, counters, and every registered output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_ready    <= 1'b0;
         r_we       <= {(NUM_BASE_BANK*NUM_POLY){1'b0}};
         r_wraddr   <= {(ADDR_WIDTH*NUM_BASE_BANK){1'b0}};
         r_data     <= {(COE_WIDTH*NUM_BASE_BANK){1'b0}};
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_word_cnt <= {ADDR_WIDTH{1'b0}};
         r_poly_idx <= {PW{1'b0}};
      end else begin
         r_we   <= {(NUM_BASE_BANK*NUM_POLY){1'b0}};
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_LOAD;
                  r_ready    <= 1'b1;
                  r_busy     <= 1'b1;
                  r_err      <= 1'b0;
                  r_word_cnt <= {ADDR_WIDTH{1'b0}};
                  r_poly_idx <= {PW{1'b0}};
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_we       <= w_we_group;
                  r_wraddr   <= {NUM_BASE_BANK{r_word_cnt}};
                  r_data     <= s_data;
                  r_word_cnt <= r_word_cnt + ADDR_WIDTH'(1'b1);
                  if (s_last != w_last_word) begin
                     r_err <= 1'b1;
                  end
                  if (w_last_word) begin
                     if (w_last_poly) begin
                        // Drop ready together with the final accept so no beat
                        // can be taken in DONE.
                        r_state <= S_DONE;
                        r_ready <= 1'b0;
                     end else begin
                        r_poly_idx <= r_poly_idx + PW'(1'b1);
                     end
                  end
               end
            end
            S_DONE: begin
               // The final write-enable cycle is the DONE cycle, so done lands
               // on the following cycle.
               r_state <= S_IDLE;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready      = r_ready;
   assign o_axi_we     = r_we;
   assign o_axi_wraddr = r_wraddr;
   assign o_axi_data   = r_data;
   assign o_done       = r_done;
   assign o_busy       = r_busy;
   assign o_err_last   = r_err;

endmodule

// File: tb/tb_dp_axi_polyvec_loader.sv
// Directed-plus-random bench for dp_axi_polyvec_loader at default parameters.
// A transaction-level model (load phase, beat count, sticky error) predicts
// every output cycle by cycle. A buffer image rebuilt from the write port is
// then compared word by word against the expected coefficients.
module tb_dp_axi_polyvec_loader;

   localparam int CW    = 39;
   localparam int AW    = 9;
   localparam int NP    = 3;
   localparam int NB    = 8;
   localparam int DW    = CW*NB;
   localparam int WORDS = 1 << AW;
   localparam int TOTAL = WORDS*NP;

   logic            clk;
   logic            rst_n;
   logic            i_start;
   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   s_data;
   logic            s_last;
   logic [NB*NP-1:0] o_axi_we;
   logic [AW*NB-1:0] o_axi_wraddr;
   logic [DW-1:0]   o_axi_data;
   logic            o_done;
   logic            o_busy;
   logic            o_err_last;

   dp_axi_polyvec_loader u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .o_axi_we     (o_axi_we),
      .o_axi_wraddr (o_axi_wraddr),
      .o_axi_data   (o_axi_data),
      .o_done       (o_done),
      .o_busy       (o_busy),
      .o_err_last   (o_err_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   // model: 0 idle, 1 loading, 2 final-write cycle
   int               m_phase = 0;
   int               m_beats = 0;
   logic             m_err   = 1'b0;
   logic [NB*NP-1:0] e_we    = '0;
   logic [AW*NB-1:0] e_addr  = '0;
   logic [DW-1:0]    e_data  = '0;
   logic             e_done  = 1'b0;

   logic [DW-1:0] mem [NP][WORDS];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int word);
      logic [DW-1:0] d;
      for (int b = 0; b < NB; b++) d[b*CW +: CW] = CW'(word*NB + b);
      return d;
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int b = 0; b < NB; b++) d[b*CW +: CW] = CW'({$urandom(), $urandom()});
      return d;
   endfunction

   // One clock: drive inputs, advance the model, then check all outputs.
   task automatic tick(input logic rn, input logic v, input logic st,
                       input logic lst, input logic [DW-1:0] d);
      int ph0;
      logic [AW-1:0] a;
      rst_n = rn; s_valid = v; i_start = st; s_last = lst; s_data = d;
      ph0 = m_phase;
      e_we = '0;
      if (!rn) begin
         m_phase = 0; m_beats = 0; m_err = 1'b0;
         e_addr = '0; e_data = '0; e_done = 1'b0;
      end else begin
         e_done = (ph0 == 2);
         if (ph0 == 0) begin
            if (st) begin m_phase = 1; m_beats = 0; m_err = 1'b0; end
         end else if (ph0 == 1) begin
            if (v) begin
               a      = AW'(m_beats % WORDS);
               e_we   = (NB*NP)'(24'hFF << (NB*(m_beats / WORDS)));
               e_addr = {NB{a}};
               e_data = d;
               if (lst != ((m_beats % WORDS) == WORDS-1)) m_err = 1'b1;
               m_beats++;
               if (m_beats == TOTAL) m_phase = 2;
            end
         end else begin
            m_phase = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (o_done) done_cnt++;
      for (int p = 0; p < NP; p++)
         if (o_axi_we[p*NB +: NB] == 8'hFF) mem[p][o_axi_wraddr[AW-1:0]] = o_axi_data;
      chk("s_ready", DW'(s_ready), DW'(m_phase == 1));
      chk("busy",    DW'(o_busy),  DW'(m_phase != 0));
      chk("we",      DW'(o_axi_we), DW'(e_we));
      chk("addr",    DW'(o_axi_wraddr), DW'(e_addr));
      chk("data",    o_axi_data, e_data);
      chk("done",    DW'(o_done), DW'(e_done));
      chk("err",     DW'(o_err_last), DW'(m_err));
   endtask

   // vmode: 0 back-to-back, 1 alternate, 2 random. stop_at >= 0 ends early.
   task automatic run_load(input int vmode, input bit bad_last, input bit poke_start,
                           input int stop_at);
      logic v, st, lst;
      logic [DW-1:0] d;
      done_cnt = 0;
      tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
      for (int c = 0; c < 20000 && m_phase != 0; c++) begin
         if (stop_at >= 0 && m_beats == stop_at) break;
         v   = (vmode == 0) ? 1'b1 : (vmode == 1) ? ~c[0] : 1'($urandom_range(0, 1));
         d   = (vmode == 0) ? pat(m_beats) : rnd_data();
         lst = ((m_beats % WORDS) == WORDS-1) || (bad_last && m_beats == 2);
         st  = poke_start && ((m_beats == 10) || (m_phase == 2));
         tick(1'b1, v, st, lst, d);
      end
      if (stop_at < 0) chk("done_pulses", DW'(done_cnt), DW'(1));
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, '0);

      // full back-to-back load with known pattern, then buffer readback
      run_load(0, 1'b0, 1'b0, -1);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int p = 0; p < NP; p++)
         for (int a = 0; a < WORDS; a++) chk("readback", mem[p][a], pat(p*WORDS + a));

      // alternating valid, random data
      run_load(1, 1'b0, 1'b0, -1);
      // random bubbles, misplaced s_last, stray i_start during LOAD and DONE
      run_load(2, 1'b1, 1'b1, -1);
      tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
      // err must clear on the next start; abandon that load with reset at beat 100
      run_load(0, 1'b0, 1'b0, 100);
      tick(1'b0, 1'b1, 1'b0, 1'b0, rnd_data());
      tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
      // fresh load after reset-abandon starts at poly 0 addr 0
      run_load(2, 1'b0, 1'b0, -1);

      // valid held high while idle: nothing accepted
      for (int i = 0; i < 50; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, rnd_data());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
